// File: rtl/pipe_ctrl_n_pkg.sv
// Shared encodings for the pipeline hold/flush controller: hold depths, bus widths, FSM states.
package pipe_ctrl_n_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int HOLD_W      = 3;
  localparam int FLUSH_CNT_W = 4;

  typedef logic [HOLD_W-1:0]      hold_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  // Hold depths are ordered so a plain unsigned compare picks the deeper stall.
  localparam hold_t HOLD_NONE = 3'd0;
  localparam hold_t HOLD_PC   = 3'd1;
  localparam hold_t HOLD_IF   = 3'd2;
  localparam hold_t HOLD_ID   = 3'd3;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic JUMP_ENABLE = 1'b1;
  localparam logic HOLD_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic hold_t hold_max(input hold_t a, input hold_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_n_hold_max_sel.sv
// Deepest hold level among the asserted request sources; HOLD_NONE when none request.
// Purely combinational, no backpressure.
module pipe_ctrl_n_hold_max_sel
  import pipe_ctrl_n_pkg::*;
#(
  parameter int                        NUM_SRC   = 4,
  parameter logic [HOLD_W*NUM_SRC-1:0] SRC_LEVEL = {HOLD_ID, HOLD_ID, HOLD_PC, HOLD_ID}
) (
  input  logic [NUM_SRC-1:0] hold_req,
  output hold_t              level
);

  always_comb begin
    level = HOLD_NONE;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hold_req[i]) begin
        level = hold_max(level, SRC_LEVEL[i*HOLD_W +: HOLD_W]);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline hold/flush controller: merges hold sources, flushes after jumps, debug halt, stall watchdog.
// Jump/hold paths are 0-cycle combinational; halt ack and watchdog are registered (1 cycle).
module pipe_ctrl_n
  import pipe_ctrl_n_pkg::*;
#(
  parameter int                        NUM_SRC      = 4,
  parameter logic [HOLD_W*NUM_SRC-1:0] SRC_LEVEL    = {HOLD_ID, HOLD_ID, HOLD_PC, HOLD_ID},
  parameter int                        FLUSH_CYCLES = 2,
  parameter int                        CNT_W        = 16,
  parameter int                        TIMEOUT      = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic [NUM_SRC-1:0]     hold_req_i,
  input  logic                   halt_req_i,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic [HOLD_W-1:0]      hold_flag_o,
  output logic                   flush_o,
  output logic                   halted_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic                   stall_timeout_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]       TIMEOUT_TH = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]       CNT_MAX    = '1;

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                   timeout_q;

  hold_t req_level;
  hold_t hold_level;
  logic  flush_act;

  pipe_ctrl_n_hold_max_sel #(
    .NUM_SRC   (NUM_SRC),
    .SRC_LEVEL (SRC_LEVEL)
  ) u_hold_max_sel (
    .hold_req (hold_req_i),
    .level    (req_level)
  );

  // A jump overrides every state; otherwise the current state decides.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_act   = 1'b0;
    hold_level  = req_level;

    if (jump_flag_i == JUMP_ENABLE) begin
      flush_act  = 1'b1;
      hold_level = HOLD_PC;
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        state_d     = ST_IDLE;
        flush_cnt_d = '0;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          flush_act  = 1'b1;
          hold_level = HOLD_PC;
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d     = ST_IDLE;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
        ST_HALT: begin
          hold_level = HOLD_ID;
          if (!halt_req_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          // A halt request held through a flush is picked up here, once IDLE is reached.
          if (halt_req_i) begin
            state_d = ST_HALT;
          end
        end
      endcase
    end
  end

  // Only genuine source-driven stalls count; flush bubbles and debug halt do not.
  always_comb begin
    stall_cnt_d = '0;
    if ((hold_level != HOLD_NONE) && !flush_act && (state_q != ST_HALT)) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= (stall_cnt_q >= TIMEOUT_TH);
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign jump_flag_o     = rst & jump_flag_i;
  assign jump_addr_o     = rst ? jump_addr_i : '0;
  assign hold_flag_o     = rst ? hold_level : HOLD_NONE;
  assign flush_o         = rst & flush_act;
  assign halted_o        = rst & (state_q == ST_HALT);
  assign stall_cnt_o     = stall_cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n: jump/flush, hold merge, debug halt, watchdog and reset behaviour.
module tb_pipe_ctrl_n;

  localparam logic [2:0] H_NONE = 3'd0;
  localparam logic [2:0] H_PC   = 3'd1;
  localparam logic [2:0] H_ID   = 3'd3;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [3:0]  hold_req_i;
  logic        halt_req_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic        flush_o;
  logic        halted_o;
  logic [15:0] stall_cnt_o;
  logic        stall_timeout_o;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl_n dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .hold_req_i      (hold_req_i),
    .halt_req_i      (halt_req_i),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .hold_flag_o     (hold_flag_o),
    .flush_o         (flush_o),
    .halted_o        (halted_o),
    .stall_cnt_o     (stall_cnt_o),
    .stall_timeout_o (stall_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    hold_req_i  = 4'b0;
    halt_req_i  = 1'b0;
  endtask

  initial begin
    // Reset held with every input active: all outputs must stay zero.
    rst         = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0100;
    hold_req_i  = 4'hf;
    halt_req_i  = 1'b1;
    sample();
    check("rst_jump_flag", 32'(jump_flag_o), 32'd0);
    check("rst_jump_addr", jump_addr_o, 32'd0);
    check("rst_hold", 32'(hold_flag_o), 32'(H_NONE));
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst_timeout", 32'(stall_timeout_o), 32'd0);
    tick();
    rst = 1'b1;
    idle_inputs();
    sample();
    check("idle_hold", 32'(hold_flag_o), 32'(H_NONE));
    check("idle_flush", 32'(flush_o), 32'd0);
    tick();

    // Single jump: two flush cycles, then quiet.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0100;
    sample();
    check("j_c0_flag", 32'(jump_flag_o), 32'd1);
    check("j_c0_addr", jump_addr_o, 32'h0000_0100);
    check("j_c0_flush", 32'(flush_o), 32'd1);
    check("j_c0_hold", 32'(hold_flag_o), 32'(H_PC));
    tick();
    idle_inputs();
    sample();
    check("j_c1_flag", 32'(jump_flag_o), 32'd0);
    check("j_c1_flush", 32'(flush_o), 32'd1);
    check("j_c1_hold", 32'(hold_flag_o), 32'(H_PC));
    tick();
    sample();
    check("j_c2_flush", 32'(flush_o), 32'd0);
    check("j_c2_hold", 32'(hold_flag_o), 32'(H_NONE));
    tick();

    // Second jump in cycle 1 of the flush extends it through cycle 2.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    sample();
    check("x_c0_flush", 32'(flush_o), 32'd1);
    tick();
    jump_addr_i = 32'h0000_0300;
    sample();
    check("x_c1_flag", 32'(jump_flag_o), 32'd1);
    check("x_c1_addr", jump_addr_o, 32'h0000_0300);
    check("x_c1_flush", 32'(flush_o), 32'd1);
    tick();
    idle_inputs();
    sample();
    check("x_c2_flush", 32'(flush_o), 32'd1);
    tick();
    sample();
    check("x_c3_flush", 32'(flush_o), 32'd0);
    tick();

    // Hold merge: src1 alone is PC depth, src0 adds ID depth, a jump forces PC.
    hold_req_i = 4'b0010;
    sample();
    check("h_0010", 32'(hold_flag_o), 32'(H_PC));
    check("h_0010_flush", 32'(flush_o), 32'd0);
    tick();
    hold_req_i = 4'b0011;
    sample();
    check("h_0011", 32'(hold_flag_o), 32'(H_ID));
    check("h_cnt1", 32'(stall_cnt_o), 32'd1);
    tick();
    hold_req_i  = 4'b0001;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0400;
    sample();
    check("h_jump_hold", 32'(hold_flag_o), 32'(H_PC));
    check("h_jump_flush", 32'(flush_o), 32'd1);
    tick();
    idle_inputs();
    sample();
    check("h_flush_cnt", 32'(stall_cnt_o), 32'd0);
    tick();
    tick();

    // Halt requested during a flush waits for IDLE, then acknowledges a cycle later.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0500;
    halt_req_i  = 1'b1;
    sample();
    check("hf_c0_halted", 32'(halted_o), 32'd0);
    tick();
    jump_flag_i = 1'b0;
    sample();
    check("hf_c1_flush", 32'(flush_o), 32'd1);
    check("hf_c1_halted", 32'(halted_o), 32'd0);
    tick();
    sample();
    check("hf_c2_flush", 32'(flush_o), 32'd0);
    check("hf_c2_halted", 32'(halted_o), 32'd0);
    tick();
    sample();
    check("hf_c3_halted", 32'(halted_o), 32'd1);
    check("hf_c3_hold", 32'(hold_flag_o), 32'(H_ID));
    tick();
    sample();
    check("hf_c4_cnt", 32'(stall_cnt_o), 32'd0);
    tick();
    halt_req_i = 1'b0;
    sample();
    check("hf_drop_still", 32'(halted_o), 32'd1);
    tick();
    sample();
    check("hf_drop_low", 32'(halted_o), 32'd0);
    check("hf_drop_hold", 32'(hold_flag_o), 32'(H_NONE));
    tick();

    // Watchdog: hold from src0 for 1030 cycles, then release.
    hold_req_i = 4'b0001;
    for (int k = 0; k < 1030; k++) begin
      sample();
      if (k == 0)    check("wd_cnt0", 32'(stall_cnt_o), 32'd0);
      if (k == 1023) check("wd_to_1023", 32'(stall_timeout_o), 32'd0);
      if (k == 1024) begin
        check("wd_cnt1024", 32'(stall_cnt_o), 32'd1024);
        check("wd_to_1024", 32'(stall_timeout_o), 32'd0);
      end
      if (k == 1025) check("wd_to_1025", 32'(stall_timeout_o), 32'd1);
      tick();
    end
    hold_req_i = 4'b0;
    sample();
    check("wd_rel_cnt", 32'(stall_cnt_o), 32'd1030);
    tick();
    sample();
    check("wd_rel1_cnt", 32'(stall_cnt_o), 32'd0);
    check("wd_rel1_to", 32'(stall_timeout_o), 32'd1);
    tick();
    sample();
    check("wd_rel2_to", 32'(stall_timeout_o), 32'd0);
    tick();

    // Reset mid-flush: outputs drop at once, nothing resumes after release.
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0600;
    tick();
    jump_flag_i = 1'b0;
    rst         = 1'b0;
    sample();
    check("rf_flush", 32'(flush_o), 32'd0);
    check("rf_hold", 32'(hold_flag_o), 32'(H_NONE));
    check("rf_addr", jump_addr_o, 32'd0);
    tick();
    rst = 1'b1;
    idle_inputs();
    sample();
    check("rf_rel_flush", 32'(flush_o), 32'd0);
    check("rf_rel_flag", 32'(jump_flag_o), 32'd0);
    check("rf_rel_hold", 32'(hold_flag_o), 32'(H_NONE));
    tick();

    // Reset while halted.
    halt_req_i = 1'b1;
    tick();
    sample();
    check("rh_halted", 32'(halted_o), 32'd1);
    tick();
    rst        = 1'b0;
    halt_req_i = 1'b0;
    sample();
    check("rh_rst_halted", 32'(halted_o), 32'd0);
    tick();
    rst = 1'b1;
    sample();
    check("rh_rel_halted", 32'(halted_o), 32'd0);
    check("rh_rel_hold", 32'(hold_flag_o), 32'(H_NONE));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
